conv_input_pad_loader: RTL and testbench

- Upstream feeder of the ping-pong input buffer, in the i_clk_input domain.
- Accepts a raw IMG_W x IMG_H 8-bit pixel stream through a valid/ready handshake.
- Inserts a PAD-wide zero border and writes the padded frame as a byte stream ((IMG_W+2*PAD)*(IMG_H+2*PAD) bytes; 1156 at defaults) into the buffer's data/valid inputs.
- Once the buffer reports full and the consumer has released the other bank, it toggles the ping-pong select so the next frame fills the opposite bank.

---
 rtl/conv_input_pad_loader_if.sv | 19 +
 rtl/conv_input_pad_loader.sv | 143 ++++++++++++++
 tb/tb_conv_input_pad_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_input_pad_loader_if.sv
// Raw pixel valid/ready channel feeding the pad loader.
// The source drives data/valid; the loader drives ready.
interface conv_input_pad_loader_if;
  logic [7:0] i_pix_data;
  logic       i_pix_vld;
  logic       o_pix_rdy;

  modport master (
    output i_pix_data,
    output i_pix_vld,
    input  o_pix_rdy
  );

  modport slave (
    input  i_pix_data,
    input  i_pix_vld,
    output o_pix_rdy
  );
endinterface

// File: rtl/conv_input_pad_loader.sv
// Zero-pads a raw pixel stream into the ping-pong input buffer
// and swaps banks once the buffer is full and the consumer is free.
module conv_input_pad_loader #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int PAD   = 1
) (
  input  logic        i_clk_input,
  input  logic        i_rst_n,
  input  logic        i_en,
  conv_input_pad_loader_if.slave s_pix,
  output logic [7:0]  o_data_din,
  output logic        o_data_din_vld,
  input  logic        i_buf_ready,
  input  logic        i_consumer_free,
  output logic        o_switch_pingpong,
  output logic        o_frame_done,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt
);

  localparam int PW = IMG_W + 2 * PAD;
  localparam int PH = IMG_H + 2 * PAD;
  localparam int CW = (PW > 1) ? $clog2(PW) : 1;
  localparam int RW = (PH > 1) ? $clog2(PH) : 1;

  localparam logic [CW-1:0] C_LO  = CW'(PAD);
  localparam logic [CW-1:0] C_HI  = CW'(PAD + IMG_W - 1);
  localparam logic [CW-1:0] C_END = CW'(PW - 1);
  localparam logic [RW-1:0] R_LO  = RW'(PAD);
  localparam logic [RW-1:0] R_HI  = RW'(PAD + IMG_H - 1);
  localparam logic [RW-1:0] R_END = RW'(PH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT_FULL,
    ST_SWAP
  } state_t;

  state_t      r_state, w_state;
  logic [RW-1:0] r_r, w_r;
  logic [CW-1:0] r_c, w_c;
  logic [7:0]  r_dout, w_dout;
  logic        r_vld, w_vld;
  logic        r_sw, w_sw;
  logic        r_done, w_done;
  logic [15:0] r_cnt, w_cnt;

  logic w_inside;
  logic w_c_end;
  logic w_last;
  logic w_step;

  assign w_inside = (r_c >= C_LO) && (r_c <= C_HI) &&
                    (r_r >= R_LO) && (r_r <= R_HI);
  assign w_c_end  = (r_c == C_END);
  assign w_last   = w_c_end && (r_r == R_END);
  // Border slots never wait; interior slots wait for a pixel.
  assign w_step   = !w_inside || s_pix.i_pix_vld;

  assign s_pix.o_pix_rdy = (r_state == ST_STREAM) && w_inside;

  always_comb begin
    w_state = r_state;
    w_r     = r_r;
    w_c     = r_c;
    w_dout  = r_dout;
    w_vld   = 1'b0;
    w_sw    = r_sw;
    w_done  = 1'b0;
    w_cnt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (i_en) begin
          w_state = ST_STREAM;
          w_r     = '0;
          w_c     = '0;
        end
      end
      ST_STREAM: begin
        if (w_step) begin
          w_vld  = 1'b1;
          w_dout = w_inside ? s_pix.i_pix_data : 8'h00;
          if (w_last) begin
            w_state = ST_WAIT_FULL;
            w_r     = '0;
            w_c     = '0;
          end else if (w_c_end) begin
            w_c = '0;
            w_r = r_r + 1'b1;
          end else begin
            w_c = r_c + 1'b1;
          end
        end
      end
      ST_WAIT_FULL: begin
        if (i_buf_ready) w_state = ST_SWAP;
      end
      ST_SWAP: begin
        if (i_consumer_free) begin
          w_sw    = ~r_sw;
          w_done  = 1'b1;
          w_cnt   = r_cnt + 16'd1;
          w_state = i_en ? ST_STREAM : ST_IDLE;
          w_r     = '0;
          w_c     = '0;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_input) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_r     <= '0;
      r_c     <= '0;
      r_dout  <= '0;
      r_vld   <= 1'b0;
      r_sw    <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_r     <= w_r;
      r_c     <= w_c;
      r_dout  <= w_dout;
      r_vld   <= w_vld;
      r_sw    <= w_sw;
      r_done  <= w_done;
      r_cnt   <= w_cnt;
    end
  end

  assign o_data_din        = r_dout;
  assign o_data_din_vld    = r_vld;
  assign o_switch_pingpong = r_sw;
  assign o_frame_done      = r_done;
  assign o_frame_cnt       = r_cnt;
  assign o_busy            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_conv_input_pad_loader.sv
// Scoreboard bench for the pad loader: padded frames are predicted
// per frame and compared byte by byte as the loader writes them.
module tb_conv_input_pad_loader;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int P    = 1;
  localparam int PW   = W + 2 * P;
  localparam int PH   = H + 2 * P;
  localparam int DP   = PW * PH;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        buf_ready;
  logic        cfree;
  logic [7:0]  dout;
  logic        dvld;
  logic        sw;
  logic        fdone;
  logic        busy;
  logic [15:0] fcnt;

  conv_input_pad_loader_if pix_if ();

  conv_input_pad_loader #(
    .IMG_W (W),
    .IMG_H (H),
    .PAD   (P)
  ) dut (
    .i_clk_input       (clk),
    .i_rst_n           (rst_n),
    .i_en              (en),
    .s_pix             (pix_if),
    .o_data_din        (dout),
    .o_data_din_vld    (dvld),
    .i_buf_ready       (buf_ready),
    .i_consumer_free   (cfree),
    .o_switch_pingpong (sw),
    .o_frame_done      (fdone),
    .o_busy            (busy),
    .o_frame_cnt       (fcnt)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] q[$];
  int         fill = 0;
  int         acc = 0;
  int         idx = 0;
  int         src_f = 0;
  bit         pend = 1'b0;
  bit         mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int f, input int k);
    return 8'(f * 37 + k * 3 + 1);
  endfunction

  task automatic push_frame(input int f);
    for (int r = 0; r < PH; r++)
      for (int c = 0; c < PW; c++)
        if (r >= P && r < P + H && c >= P && c < P + W)
          q.push_back(pix_val(f, (r - P) * W + (c - P)));
        else
          q.push_back(8'h00);
  endtask

  // One negedge step: scoreboard, pixel source and buffer model.
  task automatic tick();
    @(negedge clk);
    if (dvld) begin
      if (q.size() == 0) chk("extra_byte", 1, 0);
      else chk("byte", dout, q.pop_front());
      fill++;
    end
    if (fdone) begin
      chk("frame_bytes", fill, DP);
      chk("frame_pix", acc, NPIX);
      fill = 0;
      acc  = 0;
    end
    if (!busy) begin
      fill = 0;
      acc  = 0;
    end
    if (pend) begin
      idx++;
      if (idx == NPIX) begin
        idx = 0;
        src_f++;
      end
    end
    pix_if.i_pix_vld  = mode ? 1'($urandom_range(0, 1)) : 1'b1;
    pix_if.i_pix_data = pix_val(src_f, idx);
    pend = pix_if.i_pix_vld && pix_if.o_pix_rdy;
    if (pend) acc++;
    buf_ready = (fill == DP);
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 6000 && !got; i++) begin
      tick();
      got = fdone;
    end
    chk("done_seen", got, 1);
  endtask

  task automatic wait_fill(input int n);
    bit got = 1'b0;
    for (int i = 0; i < 6000 && !got; i++) begin
      tick();
      got = (fill >= n);
    end
    chk("fill_seen", got, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    cfree = 1'b1;
    buf_ready = 1'b0;
    pix_if.i_pix_vld = 1'b0;
    pix_if.i_pix_data = 8'h00;
    repeat (3) tick();
    chk("rst_vld", dvld, 0);
    chk("rst_dout", dout, 0);
    chk("rst_sw", sw, 0);
    chk("rst_done", fdone, 0);
    chk("rst_cnt", fcnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", pix_if.o_pix_rdy, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_busy", busy, 0);

    push_frame(0);
    push_frame(1);
    en = 1'b1;
    wait_done();
    chk("f0_sw", sw, 1);
    chk("f0_cnt", fcnt, 1);
    mode = 1'b1;
    tick();
    chk("f0_pulse", fdone, 0);
    chk("f0_busy", busy, 1);

    wait_done();
    chk("f1_sw", sw, 0);
    chk("f1_cnt", fcnt, 2);

    mode = 1'b0;
    push_frame(2);
    cfree = 1'b0;
    wait_fill(DP);
    repeat (50) begin
      tick();
      chk("hold_done", fdone, 0);
      chk("hold_sw", sw, 0);
      chk("hold_vld", dvld, 0);
      chk("hold_busy", busy, 1);
    end
    cfree = 1'b1;
    tick();
    chk("f2_done", fdone, 1);
    chk("f2_sw", sw, 1);
    chk("f2_cnt", fcnt, 3);

    push_frame(3);
    wait_fill(500);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_vld", dvld, 0);
    chk("mid_rst_sw", sw, 0);
    chk("mid_rst_cnt", fcnt, 0);
    chk("mid_rst_busy", busy, 0);
    q.delete();
    idx = 0;
    src_f = 4;
    pend = 1'b0;
    acc = 0;
    pix_if.i_pix_data = pix_val(src_f, idx);
    push_frame(4);
    rst_n = 1'b1;

    wait_fill(100);
    en = 1'b0;
    wait_done();
    chk("f4_sw", sw, 1);
    chk("f4_cnt", fcnt, 1);
    chk("f4_busy", busy, 0);
    repeat (20) begin
      tick();
      chk("idle_vld", dvld, 0);
      chk("idle_busy2", busy, 0);
    end
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
